// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the scanning word multiplexer.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAN,
      SCAN
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 word selector built as a log2(NUM_CH)-level tree of 2:1 muxes.
module mux_nto1 #(
   parameter int NUM_CH = 16,
   parameter int WIDTH  = 8
) (
   input  logic [NUM_CH*WIDTH-1:0]   in_bus,
   input  logic [$clog2(NUM_CH)-1:0] sel,
   output logic [WIDTH-1:0]          word
);

   localparam int SEL_W = $clog2(NUM_CH);

   // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves hold the channels.
   logic [WIDTH-1:0] tree [2*NUM_CH-1];

   always_comb begin
      for (int unsigned p = 0; p < NUM_CH; p++) begin
         tree[NUM_CH-1+p] = in_bus[p*WIDTH +: WIDTH];
      end
      for (int unsigned b = 0; b < SEL_W; b++) begin
         for (int unsigned p = 0; p < (NUM_CH >> (b+1)); p++) begin
            tree[(NUM_CH >> (b+1)) - 1 + p] = sel[b]
               ? tree[2*((NUM_CH >> (b+1)) - 1 + p) + 2]
               : tree[2*((NUM_CH >> (b+1)) - 1 + p) + 1];
         end
      end
      word = tree[0];
   end

endmodule

// File: rtl/mux_scan_n.sv
// N:1 word multiplexer with registered valid/ready output; manual single-channel or auto-scan sweep.
module mux_scan_n
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*WIDTH-1:0]   in_bus,
   input  logic                      mode,
   input  logic [$clog2(NUM_CH)-1:0] sel,
   input  logic                      start,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      done
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH-1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;

   logic [SEL_W-1:0] nxt_idx;
   logic [WIDTH-1:0] nxt_word;
   logic             accept;

   mux_nto1 #(
      .NUM_CH (NUM_CH),
      .WIDTH  (WIDTH)
   ) u_mux (
      .in_bus (in_bus),
      .sel    (nxt_idx),
      .word   (nxt_word)
   );

   assign accept = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      nxt_idx     = sel;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (mode == MODE_MANUAL) begin
                  nxt_idx = sel;
                  state_d = MAN;
               end else begin
                  nxt_idx = '0;
                  cnt_d   = '0;
                  state_d = SCAN;
               end
               out_data_d  = nxt_word;
               out_ch_d    = nxt_idx;
               out_valid_d = 1'b1;
            end
         end
         MAN: begin
            if (accept) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         SCAN: begin
            if (accept) begin
               if (cnt_q == LAST_CH) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  cnt_d       = '0;
                  state_d     = IDLE;
               end else begin
                  // Next channel loads on the accepting edge for 1 word/cycle streaming.
                  nxt_idx    = cnt_q + SEL_W'(1);
                  cnt_d      = nxt_idx;
                  out_data_d = nxt_word;
                  out_ch_d   = nxt_idx;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N:1 word multiplexer with a registered output and a valid/ready output handshake.
- Two modes:
  - Manual: deliver one selected channel.
  - Auto-scan: sweep channels 0..NUM_CH-1 in order, one word per accepted transfer.
- Sits between a bank of parallel sample sources and a single serial consumer (e.g. a UART/serialiser), replacing fixed 16:1 single-bit muxes.

Parameters:
- NUM_CH, 16, number of input channels; power of 2, >= 2.
- WIDTH, 8, bits per channel word.
- SEL_W, $clog2(NUM_CH), localparam, channel index width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_CH*WIDTH  channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = auto-scan; sampled only on an accepted start.
- sel  input  SEL_W  channel for manual mode; sampled only on an accepted start.
- start  input  1  one-cycle request; accepted only when busy=0.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- busy  output  1  operation in progress (state != IDLE).
- done  output  1  one-cycle pulse after the final transfer of an operation.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0, scan counter=0. The pending word is discarded; no done pulse.
- States: IDLE, MAN, SCAN.
- IDLE, start=1:
  - mode=0: load out_data=in_bus[sel], out_ch=sel, out_valid=1; go to MAN.
  - mode=1: load out_data=in_bus[channel 0], out_ch=0, out_valid=1, counter=0; go to SCAN.
- Latency: start at edge t -> out_valid=1 after edge t (visible in cycle t+1). busy rises in the same cycle.
- Data is sampled at load time. out_data and out_ch stay stable while out_valid & !out_ready, even if in_bus changes.
- MAN, accept (out_valid & out_ready): out_valid=0, done=1 for one cycle, go to IDLE.
- SCAN, accept:
  - counter != NUM_CH-1: counter+1, load in_bus[counter+1] in the same edge. out_valid stays 1, giving back-to-back transfers at 1 word/cycle with out_ready held high.
  - counter == NUM_CH-1: out_valid=0, done=1, go to IDLE. No wrap to channel 0.
- A full scan with out_ready held high is exactly NUM_CH transfers in NUM_CH cycles; done is asserted in cycle NUM_CH+1 after start.
- start while busy=1 is ignored; mode and sel changes while busy have no effect.
- start in the same cycle as done=1: state is IDLE, so the request is accepted and the next operation's first word loads.
- done is a registered pulse; it is never asserted together with out_valid of the finished operation.
- Index arithmetic is unsigned SEL_W bits; the counter never exceeds NUM_CH-1.

Decomposition:
- Package mux_scan_pkg:
  - state enum (IDLE, MAN, SCAN).
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- Sub-module mux_nto1 (params NUM_CH, WIDTH): purely combinational word selector in_bus/sel -> word, built as a log2(NUM_CH)-level 2:1 tree. mux_scan_n instantiates one, driven by a next-index mux (sel, 0, or counter+1).
- FSM, counter and output register stay in mux_scan_n.

Test Plan:
- Reset: assert rst mid-SCAN at channel 5 with out_valid=1 -> out_valid, busy and done go 0 immediately (async); after release, out_data=0, out_ch=0, state IDLE.
- Manual: in_bus channel k = 8'hA0+k, start with mode=0, sel=9, out_ready=1 -> one cycle later out_data=8'hA9, out_ch=9; accepted that cycle; next cycle done=1, busy=0.
- Scan, no stall: same in_bus, start with mode=1, out_ready=1 -> 16 consecutive transfers with out_ch 0..15 and out_data 8'hA0..8'hAF; done=1 exactly one cycle after out_ch=15 is accepted; no 17th transfer.
- Scan, backpressure: out_ready low for 3 cycles at out_ch=4 while in_bus channels 4 and 5 are overwritten -> out_data holds the sampled 8'hA4; after out_ready returns, next word is the new channel-5 value; order is preserved with no skipped or duplicated channels.
- Ignored start: pulse start with mode=0, sel=2 during a scan at channel 7 -> scan continues 8..15 unaffected; no extra transfer.
- Back-to-back: start asserted in the done cycle of a manual operation -> new operation accepted; first word valid the following cycle.
